// File: rtl/conan_pkg.sv
// Shared constants and helpers for the step watchdog: idle timeout
// computation and the default idle counter width.
package conan_pkg;

    localparam int CNT_BITS_DEFAULT = 32;

    function automatic longint unsigned timeout_cycles(input longint unsigned hz,
                                                       input longint unsigned secs);
        return hz * secs;
    endfunction

endpackage

// File: rtl/step_watchdog_idle_counter.sv
// One step channel: toggle/pulse edge detect, idle counter saturating at
// TIMEOUT, and a registered alert level.
module idle_counter #(
    parameter int                  CNT_BITS = 32,
    parameter logic [CNT_BITS-1:0] TIMEOUT  = '1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                step,
    output logic [CNT_BITS-1:0] cnt,
    output logic                alert
);

    logic prev_step;
    logic edge_seen;

    // Either polarity counts, so toggle and pulse step styles both work.
    assign edge_seen = (step != prev_step);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_step <= 1'b0;
            cnt       <= '0;
            alert     <= 1'b0;
        end else begin
            prev_step <= step;
            if (clr || edge_seen) begin
                cnt <= '0;
            end else if (cnt != TIMEOUT) begin
                cnt <= cnt + CNT_BITS'(1);
            end
            alert <= clr ? 1'b0 : (cnt == TIMEOUT);
        end
    end

endmodule

// File: rtl/step_watchdog.sv
// Stepper idle watchdog: per-channel idle timers gated by a mask and a sticky
// arm input, latching a shutdown request until cleared.
module step_watchdog
    import conan_pkg::*;
#(
    parameter int              NSTEPDIR  = 6,
    parameter longint unsigned HZ        = 64'd48000000,
    parameter longint unsigned TIMEOUT_S = 64'd10,
    parameter int              CNT_BITS  = CNT_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NSTEPDIR-1:0] step,
    input  logic                arm_n,
    input  logic [NSTEPDIR-1:0] watch_mask,
    input  logic                clr,
    output logic [NSTEPDIR-1:0] alert,
    output logic                armed,
    output logic                req_shutdown,
    output logic [7:0]          dbg_idle
);

    localparam longint unsigned     TIMEOUT   = timeout_cycles(HZ, TIMEOUT_S);
    localparam logic [CNT_BITS-1:0] TIMEOUT_C = CNT_BITS'(TIMEOUT);

    if (((TIMEOUT >> CNT_BITS) != 0) || (CNT_BITS < 8) || (TIMEOUT == 0)) begin : g_bad_cfg
        $error("step_watchdog: HZ*TIMEOUT_S must be nonzero and fit in CNT_BITS (>= 8)");
    end

    logic [CNT_BITS-1:0] idle_cnt [NSTEPDIR];
    logic                arm_meta;
    logic                arm_sync;
    logic                trip;

    for (genvar i = 0; i < NSTEPDIR; i++) begin : g_chan
        idle_counter #(
            .CNT_BITS (CNT_BITS),
            .TIMEOUT  (TIMEOUT_C)
        ) u_idle (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .step  (step[i]),
            .cnt   (idle_cnt[i]),
            .alert (alert[i])
        );
    end

    assign trip     = armed & (|(alert & watch_mask));
    assign dbg_idle = idle_cnt[NSTEPDIR-1][CNT_BITS-1 -: 8];

    // Synchronizer idles high so reset never looks like an arm request.
    // A trip or a live arm level outranks clr in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arm_meta     <= 1'b1;
            arm_sync     <= 1'b1;
            armed        <= 1'b0;
            req_shutdown <= 1'b0;
        end else begin
            arm_meta     <= arm_n;
            arm_sync     <= arm_meta;
            armed        <= ~arm_sync | (armed & ~clr);
            req_shutdown <= trip | (req_shutdown & ~clr);
        end
    end

endmodule

// File: tb/tb_step_watchdog.sv
// Scoreboard bench for step_watchdog with HZ=100, TIMEOUT_S=1 (TIMEOUT=100),
// CNT_BITS=8 so dbg_idle shows channel 5's whole idle counter.
module tb_step_watchdog;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] step = '0;
    logic       arm_n = 1'b1;
    logic [5:0] watch_mask = '0;
    logic       clr = 1'b0;
    logic [5:0] alert;
    logic       armed;
    logic       req_shutdown;
    logic [7:0] dbg_idle;

    step_watchdog #(
        .NSTEPDIR  (6),
        .HZ        (64'd100),
        .TIMEOUT_S (64'd1),
        .CNT_BITS  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .step         (step),
        .arm_n        (arm_n),
        .watch_mask   (watch_mask),
        .clr          (clr),
        .alert        (alert),
        .armed        (armed),
        .req_shutdown (req_shutdown),
        .dbg_idle     (dbg_idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        string       name;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [15:0] pk(input logic [5:0] a, input logic ar,
                                       input logic rq, input logic [7:0] d);
        return {a, ar, rq, d};
    endfunction

    function automatic void push(input int at, input string name, input logic [15:0] exp);
        exp_t e;
        int   pos;
        e.at   = at;
        e.name = name;
        e.exp  = exp;
        pos = sb.size();
        while (pos > 0 && sb[pos-1].at > at) pos--;
        sb.insert(pos, e);
    endfunction

    // Monitor: compares each expectation at the negedge of its cycle.
    always @(negedge clk) begin
        logic [15:0] act;
        exp_t        e;
        act = {alert, armed, req_shutdown, dbg_idle};
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            vectors++;
            if (e.at < cyc) begin
                miscompares++;
                $display("FAIL %s: expected at cycle %0d, missed (now %0d)", e.name, e.at, cyc);
            end else if (act !== e.exp) begin
                miscompares++;
                $display("FAIL %s @%0d: got alert=%h armed=%b req=%b dbg=%0d, want alert=%h armed=%b req=%b dbg=%0d",
                         e.name, cyc, act[15:10], act[9], act[8], act[7:0],
                         e.exp[15:10], e.exp[9], e.exp[8], e.exp[7:0]);
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Holds reset for one edge; returns at the negedge after it with rst_n released.
    task automatic do_reset(output int r);
        step  = '0;
        clr   = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        push(cyc + 1, "reset", pk(6'h00, 0, 0, 8'd0));
        @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
    endtask

    initial begin
        int r;
        int t;
        int a;
        int b;

        // No steps, never armed: all channels alert at R+101, no shutdown.
        do_reset(r);
        push(r + 1,   "cnt_start",  pk(6'h00, 0, 0, 8'd1));
        push(r + 50,  "cnt_mid",    pk(6'h00, 0, 0, 8'd50));
        push(r + 100, "cnt_top",    pk(6'h00, 0, 0, 8'd100));
        push(r + 101, "alert_all",  pk(6'h3F, 0, 0, 8'd100));
        push(r + 150, "unarmed",    pk(6'h3F, 0, 0, 8'd100));
        wait_until(r + 155);

        // Armed, only channel 5 watched; it toggles, then goes quiet.
        do_reset(r);
        arm_n      = 1'b0;
        watch_mask = 6'h20;
        push(r + 2,   "arm_sync2",  pk(6'h00, 0, 0, 8'd2));
        push(r + 3,   "armed_set",  pk(6'h00, 1, 0, 8'd3));
        push(r + 101, "ch5_busy",   pk(6'h1F, 1, 0, 8'd10));
        push(r + 180, "ch5_busy2",  pk(6'h1F, 1, 0, 8'd39));
        for (int k = 0; k < 4; k++) begin
            wait_until(r + 40 + 50 * k);
            step[5] = ~step[5];
        end
        t = cyc;
        push(t + 50,  "quiet_cnt",  pk(6'h1F, 1, 0, 8'd49));
        push(t + 101, "quiet_sat",  pk(6'h1F, 1, 0, 8'd100));
        push(t + 102, "ch5_alert",  pk(6'h3F, 1, 0, 8'd100));
        push(t + 103, "trip_102",   pk(6'h3F, 1, 1, 8'd100));
        wait_until(r + 300);

        // Mask moves to channel 0, its edge drops alert but shutdown holds; then clr.
        a = cyc;
        watch_mask = 6'h01;
        step[0]    = 1'b1;
        push(a + 1,  "edge_lag",    pk(6'h3F, 1, 1, 8'd100));
        push(a + 2,  "alert0_drop", pk(6'h3E, 1, 1, 8'd100));
        push(a + 8,  "req_sticky",  pk(6'h3E, 1, 1, 8'd100));
        wait_until(a + 3);
        arm_n = 1'b1;
        wait_until(a + 10);
        clr = 1'b1;
        push(a + 11, "clr_all",     pk(6'h00, 0, 0, 8'd0));
        push(a + 12, "clr_recount", pk(6'h00, 0, 0, 8'd1));
        @(negedge clk);
        clr = 1'b0;

        // clr in the same cycle as a trip and a live arm level.
        b = a + 10;
        @(negedge clk);
        arm_n      = 1'b0;
        watch_mask = 6'h3F;
        push(b + 101, "pre_alert",  pk(6'h00, 1, 0, 8'd100));
        push(b + 102, "alert_rise", pk(6'h3F, 1, 0, 8'd100));
        push(b + 103, "clr_trip",   pk(6'h00, 1, 1, 8'd0));
        push(b + 104, "clr_trip2",  pk(6'h00, 1, 1, 8'd1));
        wait_until(b + 102);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        wait_until(b + 106);

        // Edge exactly when counter would reach TIMEOUT vs. edge after saturation.
        arm_n = 1'b1;
        do_reset(r);
        arm_n      = 1'b0;
        watch_mask = 6'h3F;
        push(r + 100, "pre_sat",    pk(6'h00, 1, 0, 8'd100));
        push(r + 101, "edge_at_top",pk(6'h3B, 1, 0, 8'd0));
        push(r + 102, "late_edge",  pk(6'h1B, 1, 1, 8'd1));
        push(r + 200, "ch2_recount",pk(6'h1B, 1, 1, 8'd99));
        push(r + 201, "ch2_alert",  pk(6'h1F, 1, 1, 8'd100));
        push(r + 202, "ch5_alert2", pk(6'h3F, 1, 1, 8'd100));
        push(r + 300, "saturated",  pk(6'h3F, 1, 1, 8'd100));
        wait_until(r + 99);
        step[2] = 1'b1;
        @(negedge clk);
        step[5] = 1'b1;
        wait_until(r + 300);

        // One-cycle reset while tripped; edge detect restarts against prev_step=0.
        rst_n = 1'b0;
        push(r + 301, "rst_trip",   pk(6'h00, 0, 0, 8'd0));
        push(r + 302, "rst_edge",   pk(6'h00, 0, 0, 8'd0));
        push(r + 303, "rst_sync",   pk(6'h00, 0, 0, 8'd1));
        push(r + 304, "rst_rearm",  pk(6'h00, 1, 0, 8'd2));
        push(r + 402, "rst_alert",  pk(6'h1B, 1, 0, 8'd100));
        push(r + 403, "rst_trip2",  pk(6'h3F, 1, 1, 8'd100));
        @(negedge clk);
        rst_n = 1'b1;
        wait_until(r + 403);

        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: never checked (due cycle %0d)", e.name, e.at);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/step_watchdog.md
STEP_WATCHDOG -- requirements
Module: step_watchdog

Interface
REQ-001 Parameter NSTEPDIR, default 6, number of monitored step channels.
REQ-002 Parameter HZ, default 48000000, system clock frequency in Hz.
REQ-003 Parameter TIMEOUT_S, default 10, idle time in seconds before a channel alerts.
REQ-004 Parameter CNT_BITS, default 32, idle counter width; HZ*TIMEOUT_S SHALL fit in CNT_BITS (elaboration check).
REQ-005 Port clk  input  1  system clock; the block has one clock, all logic on its rising edge.
REQ-006 Port rst_n  input  1  reset, synchronous and active-low.
REQ-007 Port step  input  NSTEPDIR  step outputs from command, clk-domain, toggle-or-pulse.
REQ-008 Port arm_n  input  1  asynchronous board pin (endstop); low arms the watchdog.
REQ-009 Port watch_mask  input  NSTEPDIR  1 = channel may trigger shutdown.
REQ-010 Port clr  input  1  one-cycle pulse; clears armed, shutdown, counters.
REQ-011 Port alert  output  NSTEPDIR  per-channel idle-timeout level.
REQ-012 Port armed  output  1  sticky arm state.
REQ-013 Port req_shutdown  output  1  sticky shutdown request to command.
REQ-014 Port dbg_idle  output  8  idle_cnt[NSTEPDIR-1][CNT_BITS-1:CNT_BITS-8], for LED matrix.

Function
REQ-015 TIMEOUT = HZ*TIMEOUT_S cycles, computed at elaboration.
REQ-016 Edge detect: prev_step register; edge[i] = step[i] != prev_step[i]; both polarities count.
REQ-017 idle_cnt[i] increments by 1 per cycle, saturating at TIMEOUT; never wraps.
REQ-018 Edge in a cycle sets idle_cnt[i] to 0 next cycle; edge wins over increment and saturation.
REQ-019 alert[i] registered: alert[i] = (idle_cnt[i] == TIMEOUT), i.e. 1 cycle after counter saturates; drops 1 cycle after an edge resets the counter.
REQ-020 arm_n passes a 2-flop synchronizer; armed sets the cycle after synchronized arm_n is 0; stays set.
REQ-021 trip = armed & |(alert & watch_mask); req_shutdown sets the cycle after trip, then holds.
REQ-022 clr: next cycle armed=0, req_shutdown=0, all idle_cnt=0, alert=0.
REQ-023 clr simultaneous with trip: req_shutdown set wins (stays/becomes 1); counters still cleared.
REQ-024 clr simultaneous with synchronized arm_n=0: armed ends 1.
REQ-025 watch_mask change takes effect on the next trip evaluation; does not clear an already latched req_shutdown.
REQ-026 Channels unmasked still count and alert; only shutdown gating uses the mask.

Reset
REQ-027 rst_n low at a clock edge: idle_cnt=0, prev_step=0, sync flops=1, armed=0, req_shutdown=0, alert=0, dbg_idle=0.
REQ-028 Reset asserted mid-count or while tripped fully restarts; first edge-detect after reset compares against prev_step=0.

Structure
REQ-029 Shared package conan_pkg SHALL hold the TIMEOUT computation function and the CNT_BITS default.
REQ-030 Natural sub-module idle_counter (one channel: edge detect, saturating counter, alert flop), generated NSTEPDIR times.
REQ-031 Top-level conan instantiates step_watchdog on { step6..step1 }, endstop5 as arm_n; req_shutdown drives command.req_shutdown.

Verification (HZ=100, TIMEOUT_S=1, TIMEOUT=100, NSTEPDIR=6)
REQ-032 Reset, no steps, arm_n=1 -> alert=6'h3F at cycle 101, armed=0, req_shutdown=0 indefinitely.
REQ-033 arm_n=0 at cycle 10, watch_mask=6'h20, step[5] toggles every 50 cycles -> alert[5]=0, req_shutdown=0; stop toggling -> req_shutdown=1 exactly 102 cycles after last edge.
REQ-034 Armed, watch_mask=6'h01, channel 0 idle -> req_shutdown=1; later step edges keep it 1 until clr, then 0 next cycle, armed=0.
REQ-035 clr and trip in same cycle -> req_shutdown=1 next cycle, idle_cnt all 0.
REQ-036 Edge on step[2] in the same cycle idle_cnt[2] reaches 100 -> idle_cnt[2]=0, alert[2] never asserts.
REQ-037 rst_n low for 1 cycle while req_shutdown=1 -> all outputs 0 next cycle; counting restarts from 0.
